// File: rtl/eth_src_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// eth_src_arbiter_pkg
// Shared definitions for the source arbiter and the host-side record parser:
// FSM state encoding, counter/index widths, default header tag and the
// layout of the record header byte.
// ---------------------------------------------------------------------------
package eth_src_arbiter_pkg;

    localparam int unsigned IDX_W = 3;   // source index width (up to 8 sources)
    localparam int unsigned CNT_W = 16;  // idle counter width
    localparam int unsigned TAG_W = 5;   // header tag width

    localparam logic [TAG_W-1:0] HDR_TAG_DFLT = 5'h14;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HDR   = 2'd1,
        ST_XFER  = 2'd2,
        ST_CLOSE = 2'd3
    } state_e;

    // Record header byte: tag in the upper bits, granted source index below.
    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [IDX_W-1:0] src;
    } hdr_t;

    function automatic logic [7:0] hdr_byte(input logic [TAG_W-1:0] tag,
                                            input logic [IDX_W-1:0] src);
        hdr_t h;
        h.tag = tag;
        h.src = src;
        return 8'(h);
    endfunction

endpackage

// File: rtl/eth_src_arbiter_if.sv
// ---------------------------------------------------------------------------
// eth_src_arbiter_if
// Bundles the per-source request/byte inputs and the session write port.
//   i_req/i_valid/i_last  per-source request, byte strobe, last-byte flag
//   i_src_data            packed source bytes, source k at [8k+7:8k]
//   o_pop/o_grant         one-hot consume strobe / current grant
//   o_data/o_wr/o_din     session byte, record bracket, byte strobe
//   i_full                session back-pressure
//   o_busy/o_timeout      arbiter activity, forced-close pulse
// slave: the arbiter side; master: sources + session side.
// ---------------------------------------------------------------------------
interface eth_src_arbiter_if #(
    parameter int unsigned N_SRC = 4
);
    logic [N_SRC-1:0]   i_req;
    logic [N_SRC-1:0]   i_valid;
    logic [N_SRC-1:0]   i_last;
    logic [8*N_SRC-1:0] i_src_data;
    logic [N_SRC-1:0]   o_pop;
    logic [N_SRC-1:0]   o_grant;
    logic [7:0]         o_data;
    logic               o_wr;
    logic               o_din;
    logic               i_full;
    logic               o_busy;
    logic               o_timeout;

    modport slave (
        input  i_req, i_valid, i_last, i_src_data, i_full,
        output o_pop, o_grant, o_data, o_wr, o_din, o_busy, o_timeout
    );

    modport master (
        output i_req, i_valid, i_last, i_src_data, i_full,
        input  o_pop, o_grant, o_data, o_wr, o_din, o_busy, o_timeout
    );
endinterface

// File: rtl/eth_src_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational round-robin selector. Picks the lowest requester strictly
// above last_i, otherwise wraps to the lowest requester overall.
//   req_i     request vector
//   last_i    index of the previously served source
//   onehot_c  one-hot winner (zero when no request)
//   idx_c     winner index
//   any_c     at least one request present
// ---------------------------------------------------------------------------
module rr_pick
    import eth_src_arbiter_pkg::*;
#(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] last_i,
    output logic [N-1:0]     onehot_c,
    output logic [IDX_W-1:0] idx_c,
    output logic             any_c
);

    logic             hi_found;
    logic [IDX_W-1:0] hi_idx;
    logic [IDX_W-1:0] lo_idx;

    // Descending scan so the final write holds the lowest matching index.
    always_comb begin
        hi_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        any_c    = 1'b0;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                any_c  = 1'b1;
                lo_idx = IDX_W'(i);
                if (IDX_W'(i) > last_i) begin
                    hi_found = 1'b1;
                    hi_idx   = IDX_W'(i);
                end
            end
        end
        idx_c    = hi_found ? hi_idx : lo_idx;
        onehot_c = any_c ? (N'(1) << idx_c) : '0;
    end

endmodule

// File: rtl/eth_src_arbiter.sv
// ---------------------------------------------------------------------------
// eth_src_arbiter
// Grants one of N_SRC sources round-robin and streams its record to the
// session write port as a header byte followed by source bytes, bracketed
// by o_wr. A record ends on the source's last byte or after TIMEOUT
// consecutive cycles without an accepted byte.
//   i_clk, i_rst_n  clock, asynchronous active-low reset
//   bus             eth_src_arbiter_if slave (sources + session port)
// ---------------------------------------------------------------------------
module eth_src_arbiter
    import eth_src_arbiter_pkg::*;
#(
    parameter int unsigned      N_SRC   = 4,
    parameter logic [CNT_W-1:0] TIMEOUT = 16'd1000,
    parameter logic [TAG_W-1:0] HDR_TAG = HDR_TAG_DFLT
) (
    input logic               i_clk,
    input logic               i_rst_n,
    eth_src_arbiter_if.slave  bus
);

    state_e           state_q, state_d;
    logic [N_SRC-1:0] grant_q, grant_d;
    logic [IDX_W-1:0] gidx_q, gidx_d;
    logic [IDX_W-1:0] last_q, last_d;
    logic [CNT_W-1:0] idle_q, idle_d;
    logic             timeout_q, timeout_d;
    logic             wr_q;
    logic             busy_q;

    logic [N_SRC-1:0] pick_oh;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_any;

    logic             sel_valid;
    logic             sel_last;
    logic [7:0]       sel_data;
    logic             din_c;
    logic [7:0]       data_c;
    logic [N_SRC-1:0] pop_c;
    logic             accept_c;

    rr_pick #(.N(N_SRC)) u_rr_pick (
        .req_i    (bus.i_req),
        .last_i   (last_q),
        .onehot_c (pick_oh),
        .idx_c    (pick_idx),
        .any_c    (pick_any)
    );

    // Granted source's strobes and byte; other sources are masked out.
    assign sel_valid = |(bus.i_valid & grant_q);
    assign sel_last  = |(bus.i_last & grant_q);

    always_comb begin
        sel_data = '0;
        for (int k = 0; k < int'(N_SRC); k++) begin
            if (grant_q[k]) sel_data = sel_data | bus.i_src_data[8*k +: 8];
        end
    end

    // Session port drive; byte strobe and pop follow the live source inputs.
    always_comb begin
        din_c  = 1'b0;
        data_c = '0;
        pop_c  = '0;
        unique case (state_q)
            ST_HDR: begin
                din_c  = 1'b1;
                data_c = hdr_byte(HDR_TAG, gidx_q);
            end
            ST_XFER: begin
                din_c  = sel_valid;
                data_c = sel_data;
                pop_c  = bus.i_full ? '0 : (bus.i_valid & grant_q);
            end
            default: ;
        endcase
    end

    assign accept_c = wr_q & din_c & ~bus.i_full;

    // Next-state logic.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        gidx_d    = gidx_q;
        last_d    = last_q;
        idle_d    = '0;
        timeout_d = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    grant_d = pick_oh;
                    gidx_d  = pick_idx;
                    state_d = ST_HDR;
                end
            end
            ST_HDR: begin
                if (accept_c) state_d = ST_XFER;
            end
            ST_XFER: begin
                if (accept_c) begin
                    if (sel_last) begin
                        state_d = ST_CLOSE;
                        grant_d = '0;
                        last_d  = gidx_q;
                    end
                end else if (idle_q + CNT_W'(1) == TIMEOUT) begin
                    // Stalls and idle source both count toward the forced close.
                    state_d   = ST_CLOSE;
                    grant_d   = '0;
                    last_d    = gidx_q;
                    timeout_d = 1'b1;
                end else begin
                    idle_d = idle_q + CNT_W'(1);
                end
            end
            ST_CLOSE: begin
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and registered outputs; reset forces o_wr low at once.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= ST_IDLE;
            grant_q   <= '0;
            gidx_q    <= '0;
            last_q    <= IDX_W'(N_SRC - 1);
            idle_q    <= '0;
            timeout_q <= 1'b0;
            wr_q      <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            gidx_q    <= gidx_d;
            last_q    <= last_d;
            idle_q    <= idle_d;
            timeout_q <= timeout_d;
            wr_q      <= (state_d == ST_HDR) || (state_d == ST_XFER);
            busy_q    <= (state_d != ST_IDLE);
        end
    end

    assign bus.o_pop     = pop_c;
    assign bus.o_grant   = grant_q;
    assign bus.o_data    = data_c;
    assign bus.o_wr      = wr_q;
    assign bus.o_din     = din_c;
    assign bus.o_busy    = busy_q;
    assign bus.o_timeout = timeout_q;

endmodule

// File: tb/tb_eth_src_arbiter.sv
// ---------------------------------------------------------------------------
// tb_eth_src_arbiter
// Directed bench for eth_src_arbiter (N_SRC=4, TIMEOUT=8). Inputs are
// driven just after each falling edge and outputs sampled 1 ns later.
// ---------------------------------------------------------------------------
module tb_eth_src_arbiter;

    localparam int unsigned N = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk  = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    eth_src_arbiter_if #(.N_SRC(N)) bus ();

    eth_src_arbiter #(
        .N_SRC   (N),
        .TIMEOUT (16'd8),
        .HDR_TAG (5'h14)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic outs(input string tag, input logic wr, input logic din,
                        input logic [7:0] data, input logic [N-1:0] grant,
                        input logic [N-1:0] pop);
        chk({tag, ".wr"},    32'(bus.o_wr),    32'(wr));
        chk({tag, ".din"},   32'(bus.o_din),   32'(din));
        chk({tag, ".data"},  32'(bus.o_data),  32'(data));
        chk({tag, ".grant"}, 32'(bus.o_grant), 32'(grant));
        chk({tag, ".pop"},   32'(bus.o_pop),   32'(pop));
    endtask

    task automatic drv(input logic [N-1:0] req, input logic [N-1:0] valid,
                       input logic [N-1:0] last, input logic [31:0] data,
                       input logic full);
        @(negedge clk);
        bus.i_req      = req;
        bus.i_valid    = valid;
        bus.i_last     = last;
        bus.i_src_data = data;
        bus.i_full     = full;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus.i_req = '0; bus.i_valid = '0; bus.i_last = '0;
        bus.i_src_data = '0; bus.i_full = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]   hdr_exp [5];
        logic [7:0]   dat_exp [5];
        logic [N-1:0] gnt_exp [5];
        hdr_exp = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA0};
        dat_exp = '{8'hF0, 8'hF1, 8'hF2, 8'hF3, 8'hF0};
        gnt_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

        bus.i_req = '0; bus.i_valid = '0; bus.i_last = '0;
        bus.i_src_data = '0; bus.i_full = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        outs("rst", 1'b0, 1'b0, 8'h00, 4'b0000, 4'b0000);
        chk("rst.busy", 32'(bus.o_busy), 32'd0);
        chk("rst.tmo",  32'(bus.o_timeout), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single source 0, bytes 11,22,33; request dropped mid-record
        drv(4'b0001, 4'b0001, 4'b0000, 32'h0000_0011, 1'b0);
        outs("s1.idle", 1'b0, 1'b0, 8'h00, 4'b0000, 4'b0000);
        drv(4'b0001, 4'b0001, 4'b0000, 32'h0000_0011, 1'b0);
        outs("s1.hdr", 1'b1, 1'b1, 8'hA0, 4'b0001, 4'b0000);
        chk("s1.busy", 32'(bus.o_busy), 32'd1);
        drv(4'b0000, 4'b0001, 4'b0000, 32'h0000_0011, 1'b0);
        outs("s1.b0", 1'b1, 1'b1, 8'h11, 4'b0001, 4'b0001);
        drv(4'b0000, 4'b0001, 4'b0000, 32'h0000_0022, 1'b0);
        outs("s1.b1", 1'b1, 1'b1, 8'h22, 4'b0001, 4'b0001);
        drv(4'b0000, 4'b0001, 4'b0001, 32'h0000_0033, 1'b0);
        outs("s1.b2", 1'b1, 1'b1, 8'h33, 4'b0001, 4'b0001);
        drv(4'b0000, 4'b0000, 4'b0000, 32'h0, 1'b0);
        outs("s1.close", 1'b0, 1'b0, 8'h00, 4'b0000, 4'b0000);
        chk("s1.close.busy", 32'(bus.o_busy), 32'd1);
        drv(4'b0000, 4'b0000, 4'b0000, 32'h0, 1'b0);
        outs("s1.idle2", 1'b0, 1'b0, 8'h00, 4'b0000, 4'b0000);
        chk("s1.idle2.busy", 32'(bus.o_busy), 32'd0);

        // Sources 1 and 3 together after reset: 1 then 3, no interleave
        do_reset();
        drv(4'b1010, 4'b1010, 4'b1010, 32'hC300_5A00, 1'b0);
        outs("s2.idle", 1'b0, 1'b0, 8'h00, 4'b0000, 4'b0000);
        drv(4'b1010, 4'b1010, 4'b1010, 32'hC300_5A00, 1'b0);
        outs("s2.hdr1", 1'b1, 1'b1, 8'hA1, 4'b0010, 4'b0000);
        drv(4'b1010, 4'b1010, 4'b1010, 32'hC300_5A00, 1'b0);
        outs("s2.x1", 1'b1, 1'b1, 8'h5A, 4'b0010, 4'b0010);
        drv(4'b1000, 4'b1000, 4'b1000, 32'hC300_0000, 1'b0);
        outs("s2.close1", 1'b0, 1'b0, 8'h00, 4'b0000, 4'b0000);
        drv(4'b1000, 4'b1000, 4'b1000, 32'hC300_0000, 1'b0);
        outs("s2.gap", 1'b0, 1'b0, 8'h00, 4'b0000, 4'b0000);
        drv(4'b1000, 4'b1000, 4'b1000, 32'hC300_0000, 1'b0);
        outs("s2.hdr3", 1'b1, 1'b1, 8'hA3, 4'b1000, 4'b0000);
        drv(4'b1000, 4'b1000, 4'b1000, 32'hC300_0000, 1'b0);
        outs("s2.x3", 1'b1, 1'b1, 8'hC3, 4'b1000, 4'b1000);
        drv(4'b0000, 4'b0000, 4'b0000, 32'h0, 1'b0);
        outs("s2.close3", 1'b0, 1'b0, 8'h00, 4'b0000, 4'b0000);
        drv(4'b0000, 4'b0000, 4'b0000, 32'h0, 1'b0);
        outs("s2.idle2", 1'b0, 1'b0, 8'h00, 4'b0000, 4'b0000);

        // Source 2 with a 5-cycle i_full stall on its second byte
        drv(4'b0100, 4'b0100, 4'b0000, 32'h0001_0000, 1'b0);
        outs("s3.idle", 1'b0, 1'b0, 8'h00, 4'b0000, 4'b0000);
        drv(4'b0100, 4'b0100, 4'b0000, 32'h0001_0000, 1'b0);
        outs("s3.hdr", 1'b1, 1'b1, 8'hA2, 4'b0100, 4'b0000);
        drv(4'b0100, 4'b0100, 4'b0000, 32'h0001_0000, 1'b0);
        outs("s3.b0", 1'b1, 1'b1, 8'h01, 4'b0100, 4'b0100);
        for (int i = 0; i < 5; i++) begin
            drv(4'b0100, 4'b0100, 4'b0000, 32'h0002_0000, 1'b1);
            outs("s3.stall", 1'b1, 1'b1, 8'h02, 4'b0100, 4'b0000);
        end
        drv(4'b0100, 4'b0100, 4'b0000, 32'h0002_0000, 1'b0);
        outs("s3.b1", 1'b1, 1'b1, 8'h02, 4'b0100, 4'b0100);
        drv(4'b0100, 4'b0100, 4'b0100, 32'h0003_0000, 1'b0);
        outs("s3.b2", 1'b1, 1'b1, 8'h03, 4'b0100, 4'b0100);
        drv(4'b0000, 4'b0000, 4'b0000, 32'h0, 1'b0);
        outs("s3.close", 1'b0, 1'b0, 8'h00, 4'b0000, 4'b0000);
        drv(4'b0000, 4'b0000, 4'b0000, 32'h0, 1'b0);
        outs("s3.idle2", 1'b0, 1'b0, 8'h00, 4'b0000, 4'b0000);

        // Source 0 goes silent after 2 bytes: forced close, then source 1
        drv(4'b0011, 4'b0011, 4'b0010, 32'h0000_E1D0, 1'b0);
        outs("s4.idle", 1'b0, 1'b0, 8'h00, 4'b0000, 4'b0000);
        drv(4'b0011, 4'b0011, 4'b0010, 32'h0000_E1D0, 1'b0);
        outs("s4.hdr0", 1'b1, 1'b1, 8'hA0, 4'b0001, 4'b0000);
        drv(4'b0011, 4'b0011, 4'b0010, 32'h0000_E1D0, 1'b0);
        outs("s4.b0", 1'b1, 1'b1, 8'hD0, 4'b0001, 4'b0001);
        drv(4'b0011, 4'b0011, 4'b0010, 32'h0000_E1D1, 1'b0);
        outs("s4.b1", 1'b1, 1'b1, 8'hD1, 4'b0001, 4'b0001);
        for (int i = 0; i < 8; i++) begin
            drv(4'b0010, 4'b0010, 4'b0010, 32'h0000_E100, 1'b0);
            outs("s4.wait", 1'b1, 1'b0, 8'h00, 4'b0001, 4'b0000);
            chk("s4.wait.tmo", 32'(bus.o_timeout), 32'd0);
        end
        drv(4'b0010, 4'b0010, 4'b0010, 32'h0000_E100, 1'b0);
        outs("s4.close", 1'b0, 1'b0, 8'h00, 4'b0000, 4'b0000);
        chk("s4.close.tmo", 32'(bus.o_timeout), 32'd1);
        drv(4'b0010, 4'b0010, 4'b0010, 32'h0000_E100, 1'b0);
        outs("s4.gap", 1'b0, 1'b0, 8'h00, 4'b0000, 4'b0000);
        chk("s4.gap.tmo", 32'(bus.o_timeout), 32'd0);
        drv(4'b0010, 4'b0010, 4'b0010, 32'h0000_E100, 1'b0);
        outs("s4.hdr1", 1'b1, 1'b1, 8'hA1, 4'b0010, 4'b0000);
        drv(4'b0010, 4'b0010, 4'b0010, 32'h0000_E100, 1'b0);
        outs("s4.x1", 1'b1, 1'b1, 8'hE1, 4'b0010, 4'b0010);
        drv(4'b0000, 4'b0000, 4'b0000, 32'h0, 1'b0);
        outs("s4.close1", 1'b0, 1'b0, 8'h00, 4'b0000, 4'b0000);
        chk("s4.close1.tmo", 32'(bus.o_timeout), 32'd0);
        drv(4'b0000, 4'b0000, 4'b0000, 32'h0, 1'b0);
        outs("s4.idle2", 1'b0, 1'b0, 8'h00, 4'b0000, 4'b0000);

        // All four requesting 1-byte records: 0,1,2,3,0 with 2-cycle gaps
        do_reset();
        drv(4'b1111, 4'b1111, 4'b1111, 32'hF3F2_F1F0, 1'b0);
        outs("s5.idle", 1'b0, 1'b0, 8'h00, 4'b0000, 4'b0000);
        for (int r = 0; r < 5; r++) begin
            drv(4'b1111, 4'b1111, 4'b1111, 32'hF3F2_F1F0, 1'b0);
            outs("s5.hdr", 1'b1, 1'b1, hdr_exp[r], gnt_exp[r], 4'b0000);
            drv(4'b1111, 4'b1111, 4'b1111, 32'hF3F2_F1F0, 1'b0);
            outs("s5.x", 1'b1, 1'b1, dat_exp[r], gnt_exp[r], gnt_exp[r]);
            drv(4'b1111, 4'b1111, 4'b1111, 32'hF3F2_F1F0, 1'b0);
            outs("s5.close", 1'b0, 1'b0, 8'h00, 4'b0000, 4'b0000);
            drv(4'b1111, 4'b1111, 4'b1111, 32'hF3F2_F1F0, 1'b0);
            outs("s5.gap", 1'b0, 1'b0, 8'h00, 4'b0000, 4'b0000);
        end

        // Reset during XFER of source 1: outputs drop in the same cycle
        drv(4'b1111, 4'b1111, 4'b1111, 32'hF3F2_F1F0, 1'b0);
        outs("s6.hdr", 1'b1, 1'b1, 8'hA1, 4'b0010, 4'b0000);
        drv(4'b1111, 4'b1111, 4'b1111, 32'hF3F2_F1F0, 1'b0);
        outs("s6.x", 1'b1, 1'b1, 8'hF1, 4'b0010, 4'b0010);
        rst_n = 1'b0;
        #1;
        outs("s6.rst", 1'b0, 1'b0, 8'h00, 4'b0000, 4'b0000);
        chk("s6.rst.busy", 32'(bus.o_busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        drv(4'b1111, 4'b1111, 4'b1111, 32'hF3F2_F1F0, 1'b0);
        outs("s6.hdr0", 1'b1, 1'b1, 8'hA0, 4'b0001, 4'b0000);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
